read_node_arbiter: RTL and testbench

- Shares one read_node request/response port pair among NUM_REQ requesters, e.g. parallel Dijkstra relax pipelines.
- Forwards request addresses round-robin and records the requester ID of every issued request in an in-order tag FIFO.
- Steers each returned node record (visited, page_addr, current_cost, parent_addr) back to the requester that issued it.
- read_node returns data in request order, so the tag FIFO head always identifies the owner of the current response.

---
 rtl/read_node_arbiter_if.sv | 40 ++++
 rtl/read_node_arbiter.sv | 131 +++++++++++++
 tb/tb_read_node_arbiter.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/read_node_arbiter_if.sv
// Requester, read_node and status signals of the shared read_node arbiter.
// master = arbiter side, slave = requesters plus read_node.
interface read_node_arbiter_if #(
   parameter int W_D     = 32,
   parameter int NUM_REQ = 4,
   parameter int W_ID    = 2,
   parameter int W_TAG_A = 4
);
   logic [NUM_REQ*W_D-1:0] rq_addr;
   logic [NUM_REQ-1:0]     rq_valid;
   logic [NUM_REQ-1:0]     rq_ready;
   logic [W_D-1:0]         m_req_addr;
   logic                   m_req_valid;
   logic                   m_req_ready;
   logic                   m_data_valid;
   logic                   m_data_ready;
   logic [4*W_D-1:0]       m_data;
   logic [NUM_REQ-1:0]     rsp_valid;
   logic [NUM_REQ-1:0]     rsp_ready;
   logic [4*W_D-1:0]       rsp_data;
   logic [W_ID-1:0]        rsp_id;
   logic [W_TAG_A:0]       outstanding;
   logic                   err;

   modport master (
      input  rq_addr, rq_valid, m_req_ready,
      input  m_data_valid, m_data, rsp_ready,
      output rq_ready, m_req_addr, m_req_valid,
      output m_data_ready, rsp_valid, rsp_data,
      output rsp_id, outstanding, err
   );

   modport slave (
      output rq_addr, rq_valid, m_req_ready,
      output m_data_valid, m_data, rsp_ready,
      input  rq_ready, m_req_addr, m_req_valid,
      input  m_data_ready, rsp_valid, rsp_data,
      input  rsp_id, outstanding, err
   );
endinterface

// File: rtl/read_node_arbiter.sv
// Round-robin share of one read_node port with an in-order tag FIFO.
// READ_NODE_ARB_PRIO_EN: requester 0 gets strict priority over the rest.
module read_node_arbiter #(
   parameter int W_D     = 32,
   parameter int NUM_REQ = 4,
   parameter int W_ID    = 2,
   parameter int W_TAG_A = 4
) (
   input logic CLK,
   input logic RST,
   read_node_arbiter_if.master bus
);
   localparam int DEPTH = 1 << W_TAG_A;
   localparam logic [W_ID-1:0] LAST = W_ID'(NUM_REQ - 1);

   logic [W_ID-1:0]    tag_mem [DEPTH];
   logic [W_TAG_A-1:0] wr_ptr;
   logic [W_TAG_A-1:0] rd_ptr;
   logic [W_TAG_A:0]   count;
   logic [W_ID-1:0]    rr_ptr;
   logic [W_ID-1:0]    head;
   logic               tag_full;
   logic               tag_empty;
   logic               can_load;
   logic [NUM_REQ-1:0] cand;
   logic [NUM_REQ-1:0] rot;
   logic               found;
   logic [W_ID:0]      sum;
   logic [W_ID-1:0]    sel;
   logic               grant;
   logic               rr_upd;
   logic               pop;
   logic [W_D-1:0]     sel_addr;
   logic               req_valid_q;
   logic [W_D-1:0]     req_addr_q;
   logic               err_q;

   assign tag_full  = count == (W_TAG_A+1)'(DEPTH);
   assign tag_empty = count == '0;
   assign can_load  = (!req_valid_q || bus.m_req_ready) && !tag_full;

`ifdef READ_NODE_ARB_PRIO_EN
   assign cand = bus.rq_valid & ~NUM_REQ'(1);
`else
   assign cand = bus.rq_valid;
`endif

   // rotate so bit 0 is the requester at rr_ptr
   assign rot = NUM_REQ'({cand, cand} >> rr_ptr);

   always_comb begin
      found = 1'b0;
      sum   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            found = 1'b1;
            sum   = {1'b0, rr_ptr} + (W_ID+1)'(k);
         end
      end
      if (sum >= (W_ID+1)'(NUM_REQ))
         sum = sum - (W_ID+1)'(NUM_REQ);
      sel = sum[W_ID-1:0];
`ifdef READ_NODE_ARB_PRIO_EN
      if (bus.rq_valid[0]) begin
         found = 1'b1;
         sel   = '0;
      end
`endif
   end

   assign grant = found && can_load;
`ifdef READ_NODE_ARB_PRIO_EN
   assign rr_upd = grant && (sel != '0);
`else
   assign rr_upd = grant;
`endif

   assign sel_addr = W_D'(bus.rq_addr >> (int'(sel) * W_D));
   assign bus.rq_ready = grant ? (NUM_REQ'(1) << sel) : '0;

   assign head = tag_mem[rd_ptr];
   assign pop  = bus.m_data_valid && bus.m_data_ready;

   assign bus.rsp_id    = head;
   assign bus.rsp_data  = bus.m_data;
   assign bus.rsp_valid = (bus.m_data_valid && !tag_empty) ?
                          (NUM_REQ'(1) << head) : '0;
   assign bus.m_data_ready = !tag_empty &&
                             |(bus.rsp_ready & (NUM_REQ'(1) << head));

   assign bus.m_req_valid = req_valid_q;
   assign bus.m_req_addr  = req_addr_q;
   assign bus.outstanding = count;
   assign bus.err         = err_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         req_valid_q <= 1'b0;
         req_addr_q  <= '0;
         rr_ptr      <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         err_q       <= 1'b0;
      end else begin
         if (grant) begin
            req_valid_q <= 1'b1;
            req_addr_q  <= sel_addr;
         end else if (bus.m_req_ready) begin
            req_valid_q <= 1'b0;
         end
         if (rr_upd)
            rr_ptr <= (sel == LAST) ? '0 : sel + 1'b1;
         if (grant)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (grant && !pop)
            count <= count + 1'b1;
         else if (!grant && pop)
            count <= count - 1'b1;
         if (bus.m_data_valid && tag_empty)
            err_q <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (grant)
         tag_mem[wr_ptr] <= sel;
   end
endmodule

// File: tb/tb_read_node_arbiter.sv
// Bench for read_node_arbiter: fake read_node with fixed latency and a
// queue-based reference of grants, tags and responses.
module tb_read_node_arbiter;
   localparam int W_D = 32;
   localparam int NUM_REQ = 4;
   localparam int W_ID = 2;
   localparam int W_TAG_A = 4;
   localparam int DEPTH = 16;
   localparam int BIG = 1 << 30;
`ifdef READ_NODE_ARB_PRIO_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   read_node_arbiter_if #(
      .W_D(W_D), .NUM_REQ(NUM_REQ), .W_ID(W_ID), .W_TAG_A(W_TAG_A)
   ) bus ();

   read_node_arbiter #(
      .W_D(W_D), .NUM_REQ(NUM_REQ), .W_ID(W_ID), .W_TAG_A(W_TAG_A)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   typedef struct { int id; logic [31:0] addr; } tag_t;
   typedef struct { logic [31:0] addr; int due; } rn_t;

   tag_t mq[$];
   rn_t  rn_q[$];
   int   m_rr;
   logic m_sv;
   logic [31:0] m_sa;
   logic m_err;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [3:0]  rqv, rspr;
   logic [31:0] ra [4];
   logic        mrr, force_dv;
   int          lat, serve_n;

   logic [3:0]   e_gnt, o_gnt, e_rspv, o_rspv;
   logic         e_dr, o_dr;
   int           e_id;
   logic [1:0]   o_id;
   logic [127:0] e_data, o_data;
   logic         e_mv, o_mv, e_err, o_err;
   logic [31:0]  e_ma, o_ma;
   int           e_out;
   logic [4:0]   o_out;

   function automatic logic [127:0] mk(logic [31:0] a);
      return {a ^ 32'h41, a, a ^ 32'h47, a ^ 32'h43};
   endfunction

   function automatic int onehot_idx(logic [3:0] v);
      for (int i = 0; i < 4; i++)
         if (v[i]) return i;
      return -1;
   endfunction

   task automatic drive_idle();
      bus.rq_valid = '0;
      bus.rq_addr = '0;
      bus.m_req_ready = 1'b0;
      bus.rsp_ready = '0;
      bus.m_data_valid = 1'b0;
      bus.m_data = '0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      rqv = '0; rspr = '0; mrr = 1'b0; force_dv = 1'b0;
      lat = 3; serve_n = BIG;
      for (int i = 0; i < 4; i++) ra[i] = '0;
      drive_idle();
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      mq.delete();
      rn_q.delete();
      m_rr = 0; m_sv = 1'b0; m_sa = '0; m_err = 1'b0;
   endtask

   // one clock: drive, predict, sample, advance model and fake read_node
   task automatic cycle();
      logic dv, hs, pl;
      logic [31:0] ha;
      logic [127:0] md;
      bit cl;
      int g;
      dv = force_dv ||
           (serve_n > 0 && rn_q.size() > 0 && rn_q[0].due <= cyc);
      md = (rn_q.size() > 0) ? mk(rn_q[0].addr) : 128'h0;
      bus.rq_valid = rqv;
      for (int i = 0; i < 4; i++) bus.rq_addr[i*32 +: 32] = ra[i];
      bus.m_req_ready = mrr;
      bus.rsp_ready = rspr;
      bus.m_data_valid = dv;
      bus.m_data = md;
      #1;
      cl = (!m_sv || mrr) && (mq.size() < DEPTH);
      g = -1;
      if (cl) begin
         if (PRIO && rqv[0]) g = 0;
         for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_rr + k) % 4;
            if (g < 0 && rqv[i] && !(PRIO && i == 0)) g = i;
         end
      end
      e_gnt = (g >= 0) ? (4'b1 << g) : 4'b0;
      e_rspv = '0; e_dr = 1'b0; e_id = -1; e_data = '0;
      if (mq.size() > 0) begin
         e_id = mq[0].id;
         e_dr = rspr[e_id];
         if (dv) begin
            e_rspv = 4'b1 << e_id;
            e_data = mk(mq[0].addr);
         end
      end
      o_gnt = bus.rq_ready;
      o_rspv = bus.rsp_valid;
      o_dr = bus.m_data_ready;
      o_id = bus.rsp_id;
      o_data = bus.rsp_data;
      hs = bus.m_req_valid && mrr;
      ha = bus.m_req_addr;
      pl = dv && bus.m_data_ready && (rn_q.size() > 0);
      @(posedge CLK);
      if (dv && mq.size() == 0) m_err = 1'b1;
      if (dv && e_dr) void'(mq.pop_front());
      if (g >= 0) begin
         mq.push_back('{g, ra[g]});
         m_sv = 1'b1;
         m_sa = ra[g];
         if (!(PRIO && g == 0)) m_rr = (g + 1) % 4;
      end else if (mrr) begin
         m_sv = 1'b0;
      end
      if (pl) begin
         void'(rn_q.pop_front());
         serve_n--;
      end
      if (hs) rn_q.push_back('{ha, cyc + lat});
      cyc++;
      #1;
      e_mv = m_sv; e_ma = m_sa; e_out = mq.size(); e_err = m_err;
      o_mv = bus.m_req_valid;
      o_ma = bus.m_req_addr;
      o_out = bus.outstanding;
      o_err = bus.err;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (bus.m_req_valid !== 1'b0 || bus.m_req_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_slot got v=%b a=%h want 0/0",
                  bus.m_req_valid, bus.m_req_addr);
      end
      checks++;
      if (bus.outstanding !== 5'd0 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL reset_status got out=%0d err=%b want 0/0",
                  bus.outstanding, bus.err);
      end
      checks++;
      if (bus.rq_ready !== 4'b0 || bus.rsp_valid !== 4'b0 ||
          bus.m_data_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_handshake got rq=%b rsp=%b dr=%b want 0",
                  bus.rq_ready, bus.rsp_valid, bus.m_data_ready);
      end
      rqv = 4'hF; mrr = 1'b1;
      cycle();
      checks++;
      if (o_gnt !== 4'b0001) begin
         errors++;
         $display("FAIL reset_first_grant got=%b want=0001", o_gnt);
      end
   endtask

   task automatic test_round_robin();
      int gq[$], iq[$];
      int exp_ord[6] = '{0, 1, 2, 3, 0, 1};
      int maxo = 0;
      do_reset();
      rqv = 4'hF; mrr = 1'b1; rspr = 4'hF; lat = 3;
      for (int i = 0; i < 4; i++) ra[i] = $urandom;
      repeat (14) begin
         cycle();
         checks++;
         if (o_gnt !== e_gnt) begin
            errors++;
            $display("FAIL rr_grant cyc=%0d got=%b want=%b", cyc, o_gnt, e_gnt);
         end
         if (e_rspv != 4'b0) begin
            checks++;
            if (o_rspv !== e_rspv || o_id !== e_id[1:0] || o_data !== e_data) begin
               errors++;
               $display("FAIL rr_rsp cyc=%0d got v=%b id=%0d want v=%b id=%0d",
                        cyc, o_rspv, o_id, e_rspv, e_id);
            end
         end
         if (o_rspv != 4'b0) iq.push_back(int'(o_id));
         if (o_gnt != 4'b0) gq.push_back(onehot_idx(o_gnt));
         if (int'(o_out) > maxo) maxo = int'(o_out);
      end
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (k >= gq.size() || gq[k] != exp_ord[k]) begin
            errors++;
            $display("FAIL rr_order k=%0d got=%0d want=%0d",
                     k, (k < gq.size()) ? gq[k] : -1, exp_ord[k]);
         end
         checks++;
         if (k >= iq.size() || iq[k] != exp_ord[k]) begin
            errors++;
            $display("FAIL rr_rsp_order k=%0d got=%0d want=%0d",
                     k, (k < iq.size()) ? iq[k] : -1, exp_ord[k]);
         end
      end
      checks++;
      if (maxo > 4) begin
         errors++;
         $display("FAIL rr_outstanding got max=%0d want <=4", maxo);
      end
   endtask

   task automatic test_single();
      bit seen = 1'b0;
      do_reset();
      mrr = 1'b1; rspr = 4'hF; lat = 3;
      repeat (10) cycle();
      rqv = 4'b0100; ra[2] = 32'h40;
      cycle();
      rqv = 4'b0;
      checks++;
      if (o_gnt !== 4'b0100) begin
         errors++;
         $display("FAIL single_grant got=%b want=0100", o_gnt);
      end
      checks++;
      if (o_mv !== 1'b1 || o_ma !== 32'h40) begin
         errors++;
         $display("FAIL single_slot got v=%b a=%h want 1/40", o_mv, o_ma);
      end
      for (int t = 0; t < 10 && !seen; t++) begin
         cycle();
         if (o_rspv != 4'b0) begin
            seen = 1'b1;
            checks++;
            if (o_rspv !== 4'b0100 || o_id !== 2'd2) begin
               errors++;
               $display("FAIL single_rsp got v=%b id=%0d want 0100/2", o_rspv, o_id);
            end
            checks++;
            if (o_data !== {32'h1, 32'h40, 32'h7, 32'h3}) begin
               errors++;
               $display("FAIL single_data got=%h want=%h", o_data,
                        {32'h1, 32'h40, 32'h7, 32'h3});
            end
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL single_timeout got no rsp_valid want one within 10 cycles");
      end
   endtask

   task automatic test_full();
      int ng = 0;
      do_reset();
      mrr = 1'b1; rspr = 4'hF; lat = 1; serve_n = 0;
      repeat (20) begin
         rqv = 4'($urandom_range(1, 15));
         for (int i = 0; i < 4; i++) ra[i] = $urandom;
         cycle();
         checks++;
         if (o_gnt !== e_gnt || o_out !== 5'(e_out)) begin
            errors++;
            $display("FAIL full_fill cyc=%0d got g=%b out=%0d want g=%b out=%0d",
                     cyc, o_gnt, o_out, e_gnt, e_out);
         end
         if (o_gnt != 4'b0) ng++;
      end
      checks++;
      if (ng != 16 || o_out !== 5'd16 || o_gnt !== 4'b0) begin
         errors++;
         $display("FAIL full_count got grants=%0d out=%0d rq=%b want 16/16/0000",
                  ng, o_out, o_gnt);
      end
      serve_n = 1;
      cycle();
      checks++;
      if (o_gnt !== 4'b0 || o_out !== 5'd15) begin
         errors++;
         $display("FAIL full_pop got g=%b out=%0d want 0000/15", o_gnt, o_out);
      end
      cycle();
      checks++;
      if (o_gnt === 4'b0 || o_gnt !== e_gnt || o_out !== 5'd16) begin
         errors++;
         $display("FAIL full_regrant got g=%b out=%0d want g=%b out=16",
                  o_gnt, o_out, e_gnt);
      end
   endtask

   task automatic test_stall();
      logic [31:0] a0;
      do_reset();
      mrr = 1'b0; rspr = 4'hF; lat = 2;
      rqv = 4'b0010;
      for (int i = 0; i < 4; i++) ra[i] = $urandom;
      a0 = ra[1];
      cycle();
      checks++;
      if (o_gnt !== 4'b0010) begin
         errors++;
         $display("FAIL stall_first got=%b want=0010", o_gnt);
      end
      for (int t = 0; t < 5; t++) begin
         rqv = 4'b1110;
         for (int i = 0; i < 4; i++) ra[i] = $urandom;
         cycle();
         checks++;
         if (o_gnt !== 4'b0 || o_mv !== 1'b1 || o_ma !== a0) begin
            errors++;
            $display("FAIL stall_hold t=%0d got g=%b v=%b a=%h want 0000/1/%h",
                     t, o_gnt, o_mv, o_ma, a0);
         end
      end
      mrr = 1'b1;
      cycle();
      checks++;
      if (o_gnt !== 4'b0100) begin
         errors++;
         $display("FAIL stall_rr got=%b want=0100", o_gnt);
      end
   endtask

   task automatic test_error();
      do_reset();
      force_dv = 1'b1; serve_n = 0;
      cycle();
      checks++;
      if (o_dr !== 1'b0 || o_rspv !== 4'b0) begin
         errors++;
         $display("FAIL err_ready got dr=%b v=%b want 0/0000", o_dr, o_rspv);
      end
      checks++;
      if (o_err !== 1'b1) begin
         errors++;
         $display("FAIL err_set got=%b want=1", o_err);
      end
      force_dv = 1'b0;
      repeat (5) cycle();
      checks++;
      if (o_err !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky got=%b want=1", o_err);
      end
      do_reset();
      checks++;
      if (bus.err !== 1'b0) begin
         errors++;
         $display("FAIL err_clear got=%b want=0", bus.err);
      end
   endtask

   task automatic test_random();
      do_reset();
      lat = $urandom_range(1, 4);
      repeat (400) begin
         rqv = 4'($urandom);
         for (int i = 0; i < 4; i++) ra[i] = $urandom;
         mrr = ($urandom_range(0, 3) != 0);
         rspr = 4'($urandom);
         cycle();
         checks++;
         if (o_gnt !== e_gnt || o_dr !== e_dr || o_rspv !== e_rspv) begin
            errors++;
            $display("FAIL rand_comb cyc=%0d got g=%b dr=%b v=%b want g=%b dr=%b v=%b",
                     cyc, o_gnt, o_dr, o_rspv, e_gnt, e_dr, e_rspv);
         end
         if (e_rspv != 4'b0) begin
            checks++;
            if (o_id !== e_id[1:0] || o_data !== e_data) begin
               errors++;
               $display("FAIL rand_rsp cyc=%0d got id=%0d want id=%0d",
                        cyc, o_id, e_id);
            end
         end
         checks++;
         if (o_mv !== e_mv || (e_mv && o_ma !== e_ma) ||
             o_out !== 5'(e_out) || o_err !== e_err) begin
            errors++;
            $display("FAIL rand_state cyc=%0d got v=%b a=%h out=%0d err=%b want v=%b a=%h out=%0d err=%b",
                     cyc, o_mv, o_ma, o_out, o_err, e_mv, e_ma, e_out, e_err);
         end
      end
   endtask

`ifdef READ_NODE_ARB_PRIO_EN
   task automatic test_prio();
      int exp_ord[7] = '{0, 0, 0, 1, 2, 3, 1};
      do_reset();
      mrr = 1'b1; rspr = 4'hF; lat = 2; rqv = 4'hF;
      for (int k = 0; k < 7; k++) begin
         if (k == 3) rqv = 4'b1110;
         cycle();
         checks++;
         if (o_gnt !== (4'b1 << exp_ord[k])) begin
            errors++;
            $display("FAIL prio_order k=%0d got=%b want idx %0d",
                     k, o_gnt, exp_ord[k]);
         end
      end
   endtask
`endif

   initial begin
      drive_idle();
      test_reset();
      test_round_robin();
      test_single();
      test_full();
      test_stall();
      test_error();
      test_random();
`ifdef READ_NODE_ARB_PRIO_EN
      test_prio();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule
